// File: rtl/basket_text_builder.sv
// Sale-terminal basket: 12 lines of "NAME xQQ" text kept as a flat bus for the letter renderer.
// Requests merge quantities per product, saturate at 99, and compact the list on removal.
module basket_text_builder #(
    parameter int LINES = 12,
    parameter int CHARS = 9,
    parameter int CW    = 7
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      item_valid,
    output logic                      item_ready,
    input  logic                      item_op,
    input  logic [5*CW-1:0]           item_name,
    input  logic [6:0]                item_qty,
    input  logic                      clear,
    output logic                      done,
    output logic                      err,
    output logic [3:0]                line_count,
    output logic [LINES*CHARS*CW-1:0] words
);

    localparam int              LW         = CHARS * CW;
    localparam logic [CW-1:0]   SPACE      = CW'(32);
    localparam logic [CW-1:0]   LETTER_X   = CW'(120);
    localparam logic [CW-1:0]   DIGIT_ZERO = CW'(48);
    localparam logic [LW-1:0]   BLANK      = {CHARS{SPACE}};
    localparam logic [3:0]      MAX_LINES  = 4'(LINES);
    localparam logic [6:0]      MAX_QTY    = 7'd99;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        CONV,
        WRITE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [5*CW-1:0]  names [LINES];
    logic [6:0]       qtys  [LINES];
    logic [LW-1:0]    text  [LINES];

    logic [5*CW-1:0]  cap_name;
    logic [6:0]       cap_qty;
    logic             cap_op;
    logic [3:0]       idx;
    logic [3:0]       tens;
    logic [6:0]       rem;

    logic [7:0]       sum_raw;
    logic [6:0]       sum_sat;
    logic [6:0]       cap_sat;
    logic [3:0]       last;
    logic [3:0]       nxt;

    // Saturating quantity arithmetic for both the merge and the new-line case.
    always_comb begin
        sum_raw = {1'b0, qtys[idx]} + {1'b0, cap_qty};
        sum_sat = (sum_raw > {1'b0, MAX_QTY}) ? MAX_QTY : sum_raw[6:0];
        cap_sat = (cap_qty > MAX_QTY) ? MAX_QTY : cap_qty;
    end

    assign last = line_count - 4'd1;
    assign nxt  = idx + 4'd1;

    for (genvar g = 0; g < LINES; g++) begin : g_words
        assign words[(LINES-1-g)*LW +: LW] = text[g];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            item_ready <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            line_count <= 4'd0;
            cap_name   <= '0;
            cap_qty    <= '0;
            cap_op     <= 1'b0;
            idx        <= 4'd0;
            tens       <= 4'd0;
            rem        <= 7'd0;
            for (int i = 0; i < LINES; i++) begin
                names[i] <= '0;
                qtys[i]  <= '0;
                text[i]  <= BLANK;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A request on the same cycle as clear takes priority; clear is dropped.
                    if (item_valid && item_ready) begin
                        cap_name   <= item_name;
                        cap_qty    <= item_qty;
                        cap_op     <= item_op;
                        idx        <= 4'd0;
                        item_ready <= 1'b0;
                        state      <= SEARCH;
                    end else if (clear) begin
                        line_count <= 4'd0;
                        for (int i = 0; i < LINES; i++) begin
                            text[i] <= BLANK;
                        end
                    end
                end

                SEARCH: begin
                    if (idx == line_count) begin
                        if (cap_op || cap_qty == 7'd0 || line_count == MAX_LINES) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            names[idx] <= cap_name;
                            qtys[idx]  <= cap_sat;
                            rem        <= cap_sat;
                            tens       <= 4'd0;
                            line_count <= line_count + 4'd1;
                            state      <= CONV;
                        end
                    end else if (names[idx] == cap_name) begin
                        if (cap_op) begin
                            state <= SHIFT;
                        end else if (cap_qty == 7'd0) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            qtys[idx] <= sum_sat;
                            rem       <= sum_sat;
                            tens      <= 4'd0;
                            state     <= CONV;
                        end
                    end else begin
                        idx <= nxt;
                    end
                end

                // Binary to two decimal digits by repeated subtraction; at most ten cycles.
                CONV: begin
                    if (rem >= 7'd10) begin
                        rem  <= rem - 7'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    text[idx] <= {cap_name, SPACE, LETTER_X,
                                  DIGIT_ZERO + CW'(tens), DIGIT_ZERO + CW'(rem)};
                    err       <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end

                // Slide every later line up by one, then blank the vacated tail line.
                SHIFT: begin
                    if (idx < last) begin
                        names[idx] <= names[nxt];
                        qtys[idx]  <= qtys[nxt];
                        text[idx]  <= text[nxt];
                        idx        <= nxt;
                    end else begin
                        names[last] <= '0;
                        qtys[last]  <= '0;
                        text[last]  <= BLANK;
                        line_count  <= last;
                        err         <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    item_ready <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    item_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basket_text_builder.sv
// Directed bench for basket_text_builder: latencies, text formatting, saturation,
// capacity, removal compaction, clear and mid-operation reset.
module tb_basket_text_builder;

    logic         CLK;
    logic         RST;
    logic         item_valid;
    logic         item_ready;
    logic         item_op;
    logic [34:0]  item_name;
    logic [6:0]   item_qty;
    logic         clear;
    logic         done;
    logic         err;
    logic [3:0]   line_count;
    logic [755:0] words;

    int checks = 0;
    int fails  = 0;

    localparam logic [755:0] ALL_BLANK  = {108{7'h20}};
    localparam logic [62:0]  BLANK_LINE = {9{7'h20}};

    basket_text_builder dut (
        .CLK        (CLK),
        .RST        (RST),
        .item_valid (item_valid),
        .item_ready (item_ready),
        .item_op    (item_op),
        .item_name  (item_name),
        .item_qty   (item_qty),
        .clear      (clear),
        .done       (done),
        .err        (err),
        .line_count (line_count),
        .words      (words)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [34:0] nm(input string s);
        logic [34:0] r;
        byte b;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            b = s[k];
            r = {r[27:0], b[6:0]};
        end
        return r;
    endfunction

    function automatic logic [34:0] fill_name(input int i);
        return {7'h49, 7'h54, 7'h45, 7'h4D, 7'(65 + i)};
    endfunction

    function automatic logic [62:0] line_text(input logic [34:0] name, input int qty);
        return {name, 7'h20, 7'h78, 7'(48 + qty / 10), 7'(48 + qty % 10)};
    endfunction

    function automatic logic [62:0] line_of(input int i);
        return words[(11 - i) * 63 +: 63];
    endfunction

    // Issues one request (optionally with clear held high) and returns done latency and err.
    task automatic request(input logic op, input logic [34:0] name, input logic [6:0] qty,
                           input logic clr, output int lat, output logic e);
        int w;
        w = 0;
        while (!item_ready && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        item_valid = 1'b1;
        item_op    = op;
        item_name  = name;
        item_qty   = qty;
        clear      = clr;
        @(posedge CLK); #1;
        item_valid = 1'b0;
        item_op    = 1'b0;
        item_name  = '0;
        item_qty   = '0;
        clear      = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        e = err;
        @(posedge CLK); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (words !== ALL_BLANK) begin
            fails++;
            $display("[TB] FAIL reset_words: got %h expected %h", words, ALL_BLANK);
        end
        checks++;
        if (line_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_line_count: got %0d expected 0", line_count);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_done_err: got done=%b err=%b expected 0 0", done, err);
        end
        checks++;
        if (item_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", item_ready);
        end
    endtask

    task automatic test_add_new();
        int lat;
        logic e;
        logic [62:0] exp_line;
        exp_line = {7'h41, 7'h50, 7'h50, 7'h4C, 7'h45, 7'h20, 7'h78, 7'h30, 7'h33};
        request(1'b0, nm("APPLE"), 7'd3, 1'b0, lat, e);
        checks++;
        if (lat !== 4) begin
            fails++;
            $display("[TB] FAIL add_new_latency: got %0d expected 4", lat);
        end
        checks++;
        if (e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL add_new_err: got %b expected 0", e);
        end
        checks++;
        if (line_of(0) !== exp_line) begin
            fails++;
            $display("[TB] FAIL add_new_line0: got %h expected %h", line_of(0), exp_line);
        end
        checks++;
        if (words[692:0] !== ALL_BLANK[692:0]) begin
            fails++;
            $display("[TB] FAIL add_new_rest_blank: got %h", words[692:0]);
        end
        checks++;
        if (line_count !== 4'd1) begin
            fails++;
            $display("[TB] FAIL add_new_line_count: got %0d expected 1", line_count);
        end
    endtask

    task automatic test_merge();
        int lat;
        logic e;
        logic [62:0] exp6;
        logic [62:0] exp99;
        exp6  = {7'h41, 7'h50, 7'h50, 7'h4C, 7'h45, 7'h20, 7'h78, 7'h30, 7'h36};
        exp99 = {7'h41, 7'h50, 7'h50, 7'h4C, 7'h45, 7'h20, 7'h78, 7'h39, 7'h39};
        request(1'b0, nm("APPLE"), 7'd3, 1'b0, lat, e);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL merge_first: got lat=%0d err=%b expected 4 0", lat, e);
        end
        checks++;
        if (line_of(0) !== exp6) begin
            fails++;
            $display("[TB] FAIL merge_x06: got %h expected %h", line_of(0), exp6);
        end
        request(1'b0, nm("APPLE"), 7'd98, 1'b0, lat, e);
        checks++;
        if (lat !== 13 || e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL merge_saturate_timing: got lat=%0d err=%b expected 13 0", lat, e);
        end
        checks++;
        if (line_of(0) !== exp99) begin
            fails++;
            $display("[TB] FAIL merge_x99: got %h expected %h", line_of(0), exp99);
        end
        checks++;
        if (line_count !== 4'd1) begin
            fails++;
            $display("[TB] FAIL merge_line_count: got %0d expected 1", line_count);
        end
    endtask

    task automatic test_full();
        int lat;
        logic e;
        logic [755:0] exp_words;
        do_clear();
        exp_words = ALL_BLANK;
        for (int i = 0; i < 12; i++) begin
            request(1'b0, fill_name(i), 7'(i + 1), 1'b0, lat, e);
            exp_words[(11 - i) * 63 +: 63] = line_text(fill_name(i), i + 1);
            checks++;
            if (e !== 1'b0) begin
                fails++;
                $display("[TB] FAIL fill_err_%0d: got %b expected 0", i, e);
            end
        end
        checks++;
        if (line_count !== 4'd12) begin
            fails++;
            $display("[TB] FAIL fill_line_count: got %0d expected 12", line_count);
        end
        checks++;
        if (words !== exp_words) begin
            fails++;
            $display("[TB] FAIL fill_words: got %h expected %h", words, exp_words);
        end
        request(1'b0, nm("ITEMZ"), 7'd5, 1'b0, lat, e);
        checks++;
        if (lat !== 14 || e !== 1'b1) begin
            fails++;
            $display("[TB] FAIL full_reject: got lat=%0d err=%b expected 14 1", lat, e);
        end
        checks++;
        if (words !== exp_words || line_count !== 4'd12) begin
            fails++;
            $display("[TB] FAIL full_unchanged: got count=%0d words=%h", line_count, words);
        end
        request(1'b0, fill_name(0), 7'd0, 1'b0, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1) begin
            fails++;
            $display("[TB] FAIL qty_zero_reject: got lat=%0d err=%b expected 2 1", lat, e);
        end
        checks++;
        if (words !== exp_words) begin
            fails++;
            $display("[TB] FAIL qty_zero_unchanged: got %h expected %h", words, exp_words);
        end
    endtask

    task automatic test_remove();
        int lat;
        logic e;
        do_clear();
        request(1'b0, nm("AAAAA"), 7'd1, 1'b0, lat, e);
        request(1'b0, nm("BBBBB"), 7'd2, 1'b0, lat, e);
        request(1'b0, nm("CCCCC"), 7'd3, 1'b0, lat, e);
        request(1'b1, nm("AAAAA"), 7'd0, 1'b0, lat, e);
        checks++;
        if (lat !== 5 || e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL remove_first: got lat=%0d err=%b expected 5 0", lat, e);
        end
        checks++;
        if (line_of(0) !== line_text(nm("BBBBB"), 2) || line_of(1) !== line_text(nm("CCCCC"), 3)
            || line_of(2) !== BLANK_LINE) begin
            fails++;
            $display("[TB] FAIL remove_compact: got %h %h %h", line_of(0), line_of(1), line_of(2));
        end
        checks++;
        if (line_count !== 4'd2) begin
            fails++;
            $display("[TB] FAIL remove_line_count: got %0d expected 2", line_count);
        end
        request(1'b1, nm("ZZZZZ"), 7'd0, 1'b0, lat, e);
        checks++;
        if (lat !== 4 || e !== 1'b1) begin
            fails++;
            $display("[TB] FAIL remove_absent: got lat=%0d err=%b expected 4 1", lat, e);
        end
        request(1'b1, nm("CCCCC"), 7'd0, 1'b0, lat, e);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL remove_last: got lat=%0d err=%b expected 4 0", lat, e);
        end
        checks++;
        if (line_count !== 4'd1 || line_of(1) !== BLANK_LINE
            || line_of(0) !== line_text(nm("BBBBB"), 2)) begin
            fails++;
            $display("[TB] FAIL remove_last_state: got count=%0d %h %h", line_count, line_of(0), line_of(1));
        end
    endtask

    task automatic test_clear();
        int lat;
        logic e;
        request(1'b0, nm("DDDDD"), 7'd4, 1'b1, lat, e);
        checks++;
        if (lat !== 5 || e !== 1'b0 || line_count !== 4'd2) begin
            fails++;
            $display("[TB] FAIL accept_beats_clear: got lat=%0d err=%b count=%0d expected 5 0 2", lat, e, line_count);
        end
        checks++;
        if (line_of(0) !== line_text(nm("BBBBB"), 2) || line_of(1) !== line_text(nm("DDDDD"), 4)) begin
            fails++;
            $display("[TB] FAIL accept_beats_clear_text: got %h %h", line_of(0), line_of(1));
        end
        do_clear();
        checks++;
        if (words !== ALL_BLANK || line_count !== 4'd0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clear_state: got count=%0d done=%b words=%h", line_count, done, words);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic e;
        logic seen_done;
        request(1'b1, nm("ZZZZZ"), 7'd0, 1'b0, lat, e);
        checks++;
        if (lat !== 2 || err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL empty_remove: got lat=%0d err=%b expected 2 1", lat, err);
        end
        item_valid = 1'b1;
        item_op    = 1'b0;
        item_name  = nm("MIDRS");
        item_qty   = 7'd45;
        @(posedge CLK); #1;
        item_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++;
        if (words !== ALL_BLANK || line_count !== 4'd0 || err !== 1'b0
            || done !== 1'b0 || item_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_reset_state: got count=%0d err=%b done=%b ready=%b", line_count, err, done, item_ready);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || words !== ALL_BLANK) begin
            fails++;
            $display("[TB] FAIL mid_reset_no_done: got done_seen=%b expected 0", seen_done);
        end
    endtask

    initial begin
        RST        = 1'b1;
        item_valid = 1'b0;
        item_op    = 1'b0;
        item_name  = '0;
        item_qty   = '0;
        clear      = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        test_reset();
        test_add_new();
        test_merge();
        test_full();
        test_remove();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
